// File: rtl/dmem_arbiter_if.sv
// Bus bundle joining the CPU and external requesters, the dmem arbiter and the dmem port.
interface dmem_arbiter_if;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_done, cpu_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ext_req, ext_we, ext_gnt, ext_done, ext_err;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic        dmem_ena, dmem_R, dmem_W;
    logic [31:0] dmem_addr, dmem_in_data, dmem_out_data;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_done, cpu_rdata, cpu_err,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_done, ext_rdata, ext_err,
        output dmem_ena, dmem_R, dmem_W, dmem_addr, dmem_in_data,
        input  dmem_out_data
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_done, cpu_rdata, cpu_err,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_done, ext_rdata, ext_err,
        input  dmem_ena, dmem_R, dmem_W, dmem_addr, dmem_in_data,
        output dmem_out_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester dmem arbiter: round-robin grant, Mars address mapping, fixed wait-state access.
// Define DMEM_ARB_CPU_PRIO_EN to give the CPU fixed priority over the external master.
module dmem_arbiter #(
    parameter int          MEM_LAT    = 1,
    parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
    parameter int          DMEM_DEPTH = 1024
) (
    input  logic          clk_in,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t           r_state, w_next;
    logic [3:0]       r_cnt;
    logic             r_win, r_we, r_err;
    logic [31:0]      r_idx, r_wdata;
    logic [1:0][31:0] r_rdata;

    logic [1:0]       w_req, w_gnt, w_done, w_err;
    logic             w_any, w_win, w_valid, w_we;
    logic [31:0]      w_addr, w_idx, w_wdata;
    logic             w_ena, w_rd, w_wr;
    logic [31:0]      w_maddr, w_mdata;

    assign w_req = {bus.ext_req, bus.cpu_req};
    assign w_any = |w_req;

`ifdef DMEM_ARB_CPU_PRIO_EN
    assign w_win = ~bus.cpu_req;
`else
    logic r_last;  // 1 = ext was served last

    assign w_win = (&w_req) ? ~r_last : bus.ext_req;

    always_ff @(posedge clk_in) begin
        if (reset)                        r_last <= 1'b1;
        else if (r_state == IDLE && w_any) r_last <= w_win;
    end
`endif

    // Only the winner's inputs are muxed through; the loser never reaches dmem.
    assign w_addr  = w_win ? bus.ext_addr  : bus.cpu_addr;
    assign w_we    = w_win ? bus.ext_we    : bus.cpu_we;
    assign w_wdata = w_win ? bus.ext_wdata : bus.cpu_wdata;
    assign w_idx   = (w_addr - DMEM_BASE) >> 2;
    assign w_valid = (w_addr >= DMEM_BASE) && (w_addr[1:0] == 2'b00) &&
                     (w_idx < 32'(DMEM_DEPTH));

    always_ff @(posedge clk_in) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_cnt   <= '0;
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_win   <= w_win;
                    r_we    <= w_we;
                    r_idx   <= w_idx;
                    r_wdata <= w_wdata;
                    r_err   <= ~w_valid;
                    r_cnt   <= CNT_INIT;
                    if (!w_valid) r_rdata[w_win] <= '0;
                end
                ACCESS: begin
                    if (r_cnt != 4'd0)  r_cnt <= r_cnt - 4'd1;
                    else if (!r_we)     r_rdata[r_win] <= bus.dmem_out_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = w_valid ? ACCESS : RESP;
            ACCESS:  if (r_cnt == 4'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // gnt is a decision-cycle pulse, so it is suppressed while reset overrides the decision.
    always_comb begin
        w_gnt   = '0;
        w_done  = '0;
        w_err   = '0;
        w_ena   = 1'b0;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_maddr = '0;
        w_mdata = '0;
        case (r_state)
            IDLE: if (w_any && !reset) w_gnt[w_win] = 1'b1;
            ACCESS: begin
                w_ena   = 1'b1;
                w_rd    = ~r_we;
                w_wr    = r_we;
                w_maddr = r_idx;
                w_mdata = r_wdata;
            end
            RESP: begin
                w_done[r_win] = 1'b1;
                w_err[r_win]  = r_err;
            end
            default: ;
        endcase
    end

    assign bus.cpu_gnt      = w_gnt[0];
    assign bus.ext_gnt      = w_gnt[1];
    assign bus.cpu_done     = w_done[0];
    assign bus.ext_done     = w_done[1];
    assign bus.cpu_err      = w_err[0];
    assign bus.ext_err      = w_err[1];
    assign bus.cpu_rdata    = r_rdata[0];
    assign bus.ext_rdata    = r_rdata[1];
    assign bus.dmem_ena     = w_ena;
    assign bus.dmem_R       = w_rd;
    assign bus.dmem_W       = w_wr;
    assign bus.dmem_addr    = w_maddr;
    assign bus.dmem_in_data = w_mdata;
endmodule
